// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the integer clock divider.
package clk_div_pkg;

    localparam int MIN_DIV = 2;
    localparam int MAX_DIV = 65536;

    // Low phase takes the extra cycle for odd ratios.
    function automatic int div_low_cnt(input int div);
        return div - (div / 2);
    endfunction

    function automatic int div_high_cnt(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Modulo counter that wraps to zero after reaching LIMIT.
// Exposes the value being loaded so a downstream register can stay aligned with it.
module clk_div_counter #(
    parameter int LIMIT = 3,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    // Explicit wrap keeps non-power-of-two limits from running to 2**W.
    always_comb begin
        count_next = (count == LIMIT_V) ? '0 : count + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/clk_div_sync.sv
// Integer clock divider: registered r_clk with period DIV clk cycles, low for the ceil half.
// r_clk is a plain logic signal in the clk domain, intended as a slow strobe.
module clk_div_sync
    import clk_div_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic r_clk
);

    localparam int CNT_W    = $clog2(DIV);
    localparam int LOW_CNT  = div_low_cnt(DIV);
    localparam int HIGH_CNT = div_high_cnt(DIV);

    if (DIV < MIN_DIV || DIV > MAX_DIV || (LOW_CNT + HIGH_CNT) != DIV) begin : g_bad_div
        $error("clk_div_sync: DIV=%0d outside legal range %0d..%0d", DIV, MIN_DIV, MAX_DIV);
    end

    localparam logic [CNT_W-1:0] LOW_V = CNT_W'(LOW_CNT);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_next;

    clk_div_counter #(
        .LIMIT (DIV - 1),
        .W     (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .count      (counter),
        .count_next (counter_next)
    );

    // Compare against the value being loaded so r_clk tracks the registered counter exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk <= 1'b0;
        end else begin
            r_clk <= (counter_next >= LOW_V);
        end
    end

endmodule

// File: tb/tb_clk_div_sync.sv
// Bench for clk_div_sync: four ratios in parallel against a cycles-since-reset model.
module tb_clk_div_sync;

    logic clk;
    logic rst;
    logic r_clk4, r_clk5, r_clk2, r_clk7;

    int total;
    int bad;
    int n;              // rising edges since the last edge sampled with rst = 1
    int last_rise;
    int high_run;
    int rise_cnt;
    logic prev4;
    logic found;

    clk_div_sync #(.DIV(4)) dut4 (.clk(clk), .rst(rst), .r_clk(r_clk4));
    clk_div_sync #(.DIV(5)) dut5 (.clk(clk), .rst(rst), .r_clk(r_clk5));
    clk_div_sync #(.DIV(2)) dut2 (.clk(clk), .rst(rst), .r_clk(r_clk2));
    clk_div_sync #(.DIV(7)) dut7 (.clk(clk), .rst(rst), .r_clk(r_clk7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: counter is edges-since-reset mod DIV; r_clk is high for the last floor(DIV/2) of them.
    function automatic int exp_cnt(input int div, input int edges);
        return edges % div;
    endfunction

    function automatic int exp_clk(input int div, input int edges);
        return ((edges % div) >= (div - div / 2)) ? 1 : 0;
    endfunction

    task automatic check_all();
        check("d4_cnt", int'(dut4.counter), exp_cnt(4, n));
        check("d4_clk", int'(r_clk4),       exp_clk(4, n));
        check("d5_cnt", int'(dut5.counter), exp_cnt(5, n));
        check("d5_clk", int'(r_clk5),       exp_clk(5, n));
        check("d2_cnt", int'(dut2.counter), exp_cnt(2, n));
        check("d2_clk", int'(r_clk2),       exp_clk(2, n));
        check("d7_cnt", int'(dut7.counter), exp_cnt(7, n));
        check("d7_clk", int'(r_clk7),       exp_clk(7, n));
    endtask

    // Drive rst for one edge, advance the model, then sample 1 ns after the edge.
    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        n = r ? 0 : n + 1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n     = 0;
        rst   = 1'b1;

        // Reset hold for two edges
        for (int i = 0; i < 2; i++) begin
            step(1'b1);
            check("rst_cnt4", int'(dut4.counter), 0);
            check("rst_clk4", int'(r_clk4), 0);
            check("rst_clk5", int'(r_clk5), 0);
            check("rst_clk2", int'(r_clk2), 0);
        end

        // Free run: model compare every cycle plus DIV=4 period/duty measurement
        prev4     = r_clk4;
        last_rise = -1;
        high_run  = 0;
        rise_cnt  = 0;
        for (int i = 0; i < 52; i++) begin
            step(1'b0);
            check_all();
            if (i == 1) check("latency_d4_first_rise", int'(r_clk4), 1);
            if (r_clk4) high_run++;
            if (r_clk4 && !prev4) begin
                if (last_rise >= 0) check("d4_period_ns", int'($time) - last_rise, 40);
                last_rise = int'($time);
                rise_cnt++;
            end
            if (!r_clk4 && prev4) begin
                check("d4_high_cycles", high_run, 2);
                high_run = 0;
            end
            prev4 = r_clk4;
        end
        check("d4_rise_count", rise_cnt, 13);

        // Mid-run reset while DIV=4 sits at counter = 2
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (dut4.counter == 2) found = 1'b1;
            else begin
                step(1'b0);
                check_all();
            end
        end
        check("midrst_reached_cnt2", int'(found), 1);
        check("midrst_pre_clk4", int'(r_clk4), 1);
        step(1'b1);
        check("midrst_cnt4", int'(dut4.counter), 0);
        check("midrst_clk4", int'(r_clk4), 0);
        step(1'b0);
        check("restart_cnt4", int'(dut4.counter), 1);
        check("restart_clk4", int'(r_clk4), 0);
        check_all();

        // Random reset pulses over a long run
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 23) == 0) ? 1'b1 : 1'b0);
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
